// File: rtl/vend_dispenser.sv
// ---------------------------------------------------------------------------
// vend_dispenser
//
// Dispense controller for a vending machine. It takes vend requests from the
// upstream coin FSM, runs the dispense motor until the drop sensor sees the
// item, and keeps track of the stock level and the number of completed sales.
// If the motor runs too long without an item drop, the controller locks up in
// a terminal fault state until the next reset.
//
// Parameters
//   STOCK_INIT    : items loaded at reset and on refill (1..15)
//   MOTOR_TIMEOUT : longest motor run, in cycles, before a fault (2..255)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   vend_req   in   vend level from the coin FSM; each 0->1 edge is one request
//   motor_done in   item-drop sensor, high while the item is detected
//   refill     in   operator refill strobe (honoured only when idle)
//   motor_on   out  dispense motor drive (high exactly while dispensing)
//   busy       out  high in every state other than IDLE
//   sold_out   out  high when stock is zero
//   fault      out  sticky motor-timeout flag
//   stock      out  [3:0] remaining item count
//   vend_count out  [7:0] completed dispenses, wraps 255 -> 0
// ---------------------------------------------------------------------------
module vend_dispenser #(
  parameter int STOCK_INIT    = 8,
  parameter int MOTOR_TIMEOUT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic       motor_done,
  input  logic       refill,
  output logic       motor_on,
  output logic       busy,
  output logic       sold_out,
  output logic       fault,
  output logic [3:0] stock,
  output logic [7:0] vend_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    RELEASE  = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam logic [3:0] StockLoad   = 4'(STOCK_INIT);
  localparam logic [7:0] TimeoutLast = 8'(MOTOR_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] stock_q, stock_d;
  logic [7:0] count_q, count_d;
  logic [7:0] timer_q, timer_d;
  logic       pending_q, pending_d;
  logic       fault_q, fault_d;
  logic       motor_q, motor_d;
  logic       vend_prev_q;
  logic       reqEdge;
  logic       haveStock;

  // A request is the rising edge of the vend level relative to last cycle.
  assign reqEdge   = vend_req & ~vend_prev_q;
  assign haveStock = (stock_q != 4'd0);

  // Next-state logic for the dispense FSM and its datapath registers.
  // A refill in IDLE defers any simultaneous request by parking it in the
  // pending flag, so the new stock is visible before the motor starts.
  // In DISPENSE, motor_done is tested before the timeout so a drop seen on
  // the last allowed cycle still counts as a sale.
  always_comb begin
    state_d   = state_q;
    stock_d   = stock_q;
    count_d   = count_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    fault_d   = fault_q;

    case (state_q)
      IDLE: begin
        if (refill) begin
          stock_d = StockLoad;
          if (reqEdge) begin
            pending_d = 1'b1;
          end
        end else if (pending_q) begin
          pending_d = 1'b0;
          if (haveStock) begin
            state_d = DISPENSE;
            timer_d = 8'd0;
          end
        end else if (reqEdge && haveStock) begin
          state_d = DISPENSE;
          timer_d = 8'd0;
        end
      end

      DISPENSE: begin
        if (reqEdge) begin
          pending_d = 1'b1;
        end
        timer_d = 8'(timer_q + 8'd1);
        if (motor_done) begin
          state_d = RELEASE;
          count_d = 8'(count_q + 8'd1);
          if (haveStock) begin
            stock_d = 4'(stock_q - 4'd1);
          end
        end else if (timer_q >= TimeoutLast) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
      end

      RELEASE: begin
        if (reqEdge) begin
          pending_d = 1'b1;
        end
        if (!motor_done) begin
          pending_d = 1'b0;
          if ((pending_q || reqEdge) && haveStock) begin
            state_d = DISPENSE;
            timer_d = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    motor_d = (state_d == DISPENSE);
  end

  // State register. Reset is asynchronous so the motor drops the instant
  // rst rises, abandoning any item in flight without touching stock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stock_q     <= StockLoad;
      count_q     <= 8'd0;
      timer_q     <= 8'd0;
      pending_q   <= 1'b0;
      fault_q     <= 1'b0;
      motor_q     <= 1'b0;
      vend_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stock_q     <= stock_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      fault_q     <= fault_d;
      motor_q     <= motor_d;
      vend_prev_q <= vend_req;
    end
  end

  // Status outputs decoded only from registered state and stock.
  assign motor_on   = motor_q;
  assign busy       = (state_q != IDLE);
  assign sold_out   = (stock_q == 4'd0);
  assign fault      = fault_q;
  assign stock      = stock_q;
  assign vend_count = count_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// ---------------------------------------------------------------------------
// tb_vend_dispenser
//
// Directed bench for vend_dispenser with default parameters (STOCK_INIT=8,
// MOTOR_TIMEOUT=100). Each task resets the DUT, drives one scenario and
// compares outputs against hand-worked values. Inputs change and outputs are
// sampled 1 ns after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_vend_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       vend_req;
  logic       motor_done;
  logic       refill;
  logic       motor_on;
  logic       busy;
  logic       sold_out;
  logic       fault;
  logic [3:0] stock;
  logic [7:0] vend_count;

  int vecCount = 0;
  int errCount = 0;

  vend_dispenser dut (
    .clk        (clk),
    .rst        (rst),
    .vend_req   (vend_req),
    .motor_done (motor_done),
    .refill     (refill),
    .motor_on   (motor_on),
    .busy       (busy),
    .sold_out   (sold_out),
    .fault      (fault),
    .stock      (stock),
    .vend_count (vend_count)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronously framed reset pulse; leaves inputs idle at cycle 0.
  task automatic applyReset();
    rst        = 1'b1;
    vend_req   = 1'b0;
    motor_done = 1'b0;
    refill     = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // One complete vend: request, immediate drop, sensor release.
  task automatic doVend();
    vend_req = 1'b1;
    tick();
    vend_req   = 1'b0;
    motor_done = 1'b1;
    tick();
    motor_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    vend_req   = 1'b0;
    motor_done = 1'b0;
    refill     = 1'b0;
    #3;
    vecCount++;
    if (motor_on !== 1'b0 || busy !== 1'b0 || sold_out !== 1'b0 || fault !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL reset_flags got mo=%b busy=%b so=%b fault=%b want 0 0 0 0",
               motor_on, busy, sold_out, fault);
    end
    vecCount++;
    if (stock !== 4'd8 || vend_count !== 8'd0) begin
      errCount++;
      $display("[TB] FAIL reset_counts got stock=%0d count=%0d want 8 0", stock, vend_count);
    end
    tick();
    rst = 1'b0;
    tick();
    vecCount++;
    if (busy !== 1'b0 || motor_on !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL reset_idle got busy=%b mo=%b want 0 0", busy, motor_on);
    end
  endtask

  // Request at cycle 0, sensor high during cycles 5-6.
  task automatic test_nominal();
    applyReset();
    vend_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 2) vend_req = 1'b0;
      motor_done = (c == 5 || c == 6);
      vecCount++;
      if (motor_on !== ((c >= 1 && c <= 5) ? 1'b1 : 1'b0)) begin
        errCount++;
        $display("[TB] FAIL nominal_motor cycle %0d got %b want %b", c, motor_on, (c <= 5));
      end
      vecCount++;
      if (busy !== ((c <= 7) ? 1'b1 : 1'b0)) begin
        errCount++;
        $display("[TB] FAIL nominal_busy cycle %0d got %b want %b", c, busy, (c <= 7));
      end
    end
    vecCount++;
    if (stock !== 4'd7 || vend_count !== 8'd1) begin
      errCount++;
      $display("[TB] FAIL nominal_counts got stock=%0d count=%0d want 7 1", stock, vend_count);
    end
  endtask

  // Second edge during DISPENSE is kept, third edge during RELEASE dropped.
  task automatic test_back_to_back();
    applyReset();
    vend_req = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      case (c)
        2:  vend_req = 1'b0;
        3:  vend_req = 1'b1;
        4:  motor_done = 1'b1;
        5:  vend_req = 1'b0;
        6:  vend_req = 1'b1;
        7:  motor_done = 1'b0;
        9:  motor_done = 1'b1;
        10: motor_done = 1'b0;
        default: ;
      endcase
      vecCount++;
      if (motor_on !== (((c >= 1 && c <= 4) || (c >= 8 && c <= 9)) ? 1'b1 : 1'b0)) begin
        errCount++;
        $display("[TB] FAIL b2b_motor cycle %0d got %b", c, motor_on);
      end
    end
    vecCount++;
    if (stock !== 4'd6 || vend_count !== 8'd2 || busy !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL b2b_final got stock=%0d count=%0d busy=%b want 6 2 0",
               stock, vend_count, busy);
    end
    vend_req = 1'b0;
  endtask

  // Sensor never fires: 100 dispense cycles, then terminal fault.
  task automatic test_timeout();
    applyReset();
    vend_req = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      vecCount++;
      if (motor_on !== 1'b1 || fault !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL timeout_run cycle %0d got mo=%b fault=%b want 1 0", c, motor_on, fault);
      end
    end
    tick();
    vecCount++;
    if (motor_on !== 1'b0 || fault !== 1'b1 || busy !== 1'b1 || stock !== 4'd8 || vend_count !== 8'd0) begin
      errCount++;
      $display("[TB] FAIL timeout_enter got mo=%b fault=%b busy=%b stock=%0d count=%0d want 0 1 1 8 0",
               motor_on, fault, busy, stock, vend_count);
    end
    vend_req = 1'b0;
    refill   = 1'b1;
    tick();
    refill   = 1'b0;
    vend_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      motor_done = (c == 2);
      vecCount++;
      if (motor_on !== 1'b0 || fault !== 1'b1 || busy !== 1'b1 || vend_count !== 8'd0) begin
        errCount++;
        $display("[TB] FAIL timeout_locked step %0d got mo=%b fault=%b busy=%b count=%0d",
                 c, motor_on, fault, busy, vend_count);
      end
    end
    vend_req   = 1'b0;
    motor_done = 1'b0;
  endtask

  // Eight vends empty the machine; a ninth request is ignored; refill restores.
  task automatic test_sold_out();
    applyReset();
    for (int i = 1; i <= 8; i++) begin
      doVend();
      vecCount++;
      if (stock !== 4'(8 - i) || vend_count !== 8'(i)) begin
        errCount++;
        $display("[TB] FAIL soldout_vend %0d got stock=%0d count=%0d want %0d %0d",
                 i, stock, vend_count, 8 - i, i);
      end
    end
    vecCount++;
    if (sold_out !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL soldout_flag got %b want 1", sold_out);
    end
    vend_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vecCount++;
      if (motor_on !== 1'b0 || busy !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL soldout_ignore step %0d got mo=%b busy=%b want 0 0", c, motor_on, busy);
      end
    end
    vend_req = 1'b0;
    refill   = 1'b1;
    tick();
    refill = 1'b0;
    vecCount++;
    if (stock !== 4'd8 || sold_out !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL soldout_refill got stock=%0d so=%b want 8 0", stock, sold_out);
    end
  endtask

  // Empty machine, refill and request together; refill during RELEASE ignored.
  task automatic test_refill_request();
    applyReset();
    for (int i = 0; i < 8; i++) doVend();
    refill   = 1'b1;
    vend_req = 1'b1;
    tick();
    refill = 1'b0;
    vecCount++;
    if (stock !== 4'd8 || motor_on !== 1'b0 || busy !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL refreq_load got stock=%0d mo=%b busy=%b want 8 0 0", stock, motor_on, busy);
    end
    tick();
    vecCount++;
    if (motor_on !== 1'b1 || busy !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL refreq_start got mo=%b busy=%b want 1 1", motor_on, busy);
    end
    motor_done = 1'b1;
    tick();
    motor_done = 1'b0;
    refill     = 1'b1;
    vecCount++;
    if (stock !== 4'd7 || vend_count !== 8'd9 || motor_on !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL refreq_release got stock=%0d count=%0d mo=%b want 7 9 0",
               stock, vend_count, motor_on);
    end
    tick();
    refill   = 1'b0;
    vend_req = 1'b0;
    vecCount++;
    if (stock !== 4'd7 || busy !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL refreq_busy_refill got stock=%0d busy=%b want 7 0", stock, busy);
    end
  endtask

  // Asynchronous reset between edges while dispensing; vend_req held high
  // across reset counts as a fresh request on the first edge afterwards.
  task automatic test_async_reset();
    applyReset();
    vend_req = 1'b1;
    tick();
    tick();
    vecCount++;
    if (motor_on !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL async_pre got mo=%b want 1", motor_on);
    end
    #2;
    rst = 1'b1;
    #1;
    vecCount++;
    if (motor_on !== 1'b0 || busy !== 1'b0 || stock !== 4'd8 || vend_count !== 8'd0) begin
      errCount++;
      $display("[TB] FAIL async_drop got mo=%b busy=%b stock=%0d count=%0d want 0 0 8 0",
               motor_on, busy, stock, vend_count);
    end
    #2;
    rst = 1'b0;
    tick();
    vecCount++;
    if (motor_on !== 1'b1 || busy !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL async_held_req got mo=%b busy=%b want 1 1", motor_on, busy);
    end
    vend_req = 1'b0;
  endtask

  // 256 vends with a refill after each: vend_count passes 255 and wraps to 0.
  task automatic test_count_wrap();
    applyReset();
    for (int i = 1; i <= 256; i++) begin
      doVend();
      refill = 1'b1;
      tick();
      refill = 1'b0;
      if (i == 255) begin
        vecCount++;
        if (vend_count !== 8'd255) begin
          errCount++;
          $display("[TB] FAIL wrap_255 got %0d want 255", vend_count);
        end
      end
    end
    vecCount++;
    if (vend_count !== 8'd0 || stock !== 4'd8) begin
      errCount++;
      $display("[TB] FAIL wrap_zero got count=%0d stock=%0d want 0 8", vend_count, stock);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_timeout();
    test_sold_out();
    test_refill_request();
    test_async_reset();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  // Guards against a stuck simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/vend_dispenser.md
VEND_DISPENSER -- requirements
Module: vend_dispenser

Interface
REQ-001 The module SHALL have the parameter STOCK_INIT, default 8, which is the item count loaded at reset and on refill (range 1..15).
REQ-002 The module SHALL have the parameter MOTOR_TIMEOUT, default 100, which is the maximum number of cycles the motor runs before a fault (range 2..255).
REQ-003 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, and is the reset, asynchronous and active-high.
REQ-005 The port vend_req SHALL be an input, 1 bit wide, carrying the vend level from the upstream coin FSM; each 0->1 transition is one vend request.
REQ-006 The port motor_done SHALL be an input, 1 bit wide, from the item-drop sensor, and is high while the item is detected.
REQ-007 The port refill SHALL be an input, 1 bit wide, and is the operator refill strobe.
REQ-008 The port motor_on SHALL be an output, 1 bit wide, and is the dispense motor drive.
REQ-009 The port busy SHALL be an output, 1 bit wide, and is high in any state other than IDLE.
REQ-010 The port sold_out SHALL be an output, 1 bit wide, and is high when stock == 0.
REQ-011 The port fault SHALL be an output, 1 bit wide, and is a sticky motor-timeout flag.
REQ-012 The port stock SHALL be an output, 4 bits wide, and is the remaining item count.
REQ-013 The port vend_count SHALL be an output, 8 bits wide, and is the count of completed dispenses.

Function
REQ-014 The module SHALL register vend_req into vend_prev each cycle, and a request edge SHALL be vend_req=1 with vend_prev=0.
REQ-015 The FSM SHALL have exactly four states: IDLE, DISPENSE, RELEASE and FAULT.
REQ-016 In IDLE, a request edge with stock>0 SHALL enter DISPENSE on the next edge; an edge with stock==0 SHALL be dropped and the FSM SHALL stay in IDLE.
REQ-017 motor_on SHALL be 1 exactly while the state is DISPENSE, so motor_on rises one cycle after the request edge is sampled.
REQ-018 In DISPENSE, a timer SHALL count from 0 each cycle; motor_done=1 SHALL cause the FSM to go to RELEASE, decrement stock by 1 and increment vend_count by 1, all on the same edge.
REQ-019 vend_count SHALL wrap from 255 to 0, and stock SHALL never decrement below 0.
REQ-020 In DISPENSE, if the timer reaches MOTOR_TIMEOUT-1 with motor_done=0, the FSM SHALL go to FAULT, fault SHALL be set, and stock and vend_count SHALL stay unchanged.
REQ-021 If motor_done=1 and a timeout occur in the same cycle, motor_done SHALL win and the FSM SHALL go to RELEASE.
REQ-022 In RELEASE, the FSM SHALL wait for motor_done=0; it SHALL then go to DISPENSE if pending=1 and stock>0, and otherwise go to IDLE; pending SHALL clear on leaving RELEASE.
REQ-023 A request edge while busy SHALL set a one-deep pending flag, and further edges while pending=1 SHALL be dropped.
REQ-024 FAULT SHALL be terminal: motor_on=0, busy=1, and all requests and refill are ignored until rst.
REQ-025 refill SHALL load stock=STOCK_INIT only when the state is IDLE; in other states it SHALL be ignored.
REQ-026 If refill and a request edge occur in the same IDLE cycle, refill SHALL take effect, the request SHALL be stored as pending, and the FSM SHALL enter DISPENSE on the following cycle.
REQ-027 A pending request taken in IDLE SHALL start DISPENSE and clear pending.
REQ-028 busy and sold_out SHALL be decoded combinationally from the registered state and stock only.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, stock=STOCK_INIT, vend_count=0, timer=0, pending=0, vend_prev=0 and fault=0.
REQ-030 Consequently, during reset the outputs SHALL be motor_on=0, busy=0 and sold_out=0.
REQ-031 rst asserted mid-DISPENSE SHALL drop motor_on in the same cycle and abandon the item with no stock change.
REQ-032 After rst deasserts, a vend_req already high SHALL count as a request edge on the first clk edge.

Verification
REQ-033 Scenario, nominal vend: vend_req rises at cycle 0 and motor_done is high during cycles 5-6 -> motor_on=1 in cycles 1-5, stock goes 8->7, vend_count goes 0->1, and busy=0 by cycle 8.
REQ-034 Scenario, timeout: vend_req rises and motor_done is held at 0 -> after 100 DISPENSE cycles fault=1 and motor_on=0, stock stays 8, and a later refill or vend_req has no effect until rst.
REQ-035 Scenario, sold out: 8 complete vends, then a 9th request -> sold_out=1 and no motor_on pulse; a refill in IDLE then gives stock=8 and sold_out=0.
REQ-036 Scenario, back-to-back: a second vend_req edge during DISPENSE and a third edge during RELEASE -> exactly 2 dispenses, vend_count=2 and stock=6.
REQ-037 Scenario, refill plus request in the same IDLE cycle with stock=0 -> stock=8, then DISPENSE on the next cycle, ending with stock=7.
REQ-038 Scenario, async reset: rst pulse between clk edges in mid-DISPENSE -> motor_on falls before the next edge, stock=8 and vend_count=0.
